// File: rtl/config_packet_arbiter.sv
// config_packet_arbiter: merges configuration packets from NUM_REQ sources onto
// one registered packet bus. Each source owns a 1-deep holding buffer; grants
// rotate round-robin and a source may lock the bus across a burst.
// Optional macro CFG_ARB_LOCK_TIMEOUT_EN: force-release a lock after
// LOCK_TIMEOUT consecutive locked cycles with no owner emission.
module config_packet_arbiter #(
    parameter int unsigned PACKET_BITS  = 97,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 255,
    localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ*PACKET_BITS-1:0] req_packet,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [PACKET_BITS-1:0]         configure_out,
    output logic [ID_W-1:0]                grant_id,
    output logic                           grant_valid,
    output logic                           locked,
    output logic                           lock_timeout
);

    localparam int unsigned PAY_W = PACKET_BITS - 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_REQ-1:0]     r_buf_full;
    logic [NUM_REQ-1:0]     r_buf_lock;
    logic [PAY_W-1:0]       r_buf_pay [NUM_REQ];
    logic [ID_W-1:0]        r_owner;
    logic [ID_W-1:0]        r_last_grant;
    logic [PACKET_BITS-1:0] r_cfg;
    logic [ID_W-1:0]        r_grant_id;
    logic                   r_grant_valid;
    logic                   r_locked;

    logic [NUM_REQ-1:0]     w_cand;
    logic                   w_found;
    logic [ID_W-1:0]        w_pick;
    logic                   w_to_hit;
    logic                   w_to_fire;
    logic [NUM_REQ-1:0]     w_pkt_msb;
    logic                   w_unused;

    assign req_ready     = ~r_buf_full;
    assign configure_out = r_cfg;
    assign grant_id      = r_grant_id;
    assign grant_valid   = r_grant_valid;
    assign locked        = r_locked;

    // Candidate set: every full buffer when idle, only the owner's when locked
    always_comb begin
        w_cand = r_buf_full;
        if (r_state == ST_LOCKED) begin
            w_cand = r_buf_full & (NUM_REQ'(1) << r_owner);
        end
    end

    // Round-robin search starting just after the last granted source
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && w_cand[ID_W'((32'(r_last_grant) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_pick  = ID_W'((32'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    // Lock FSM next-state: enter on a locked emission, leave on an unlocked
    // owner emission or on an idle-lock timeout
    always_comb begin
        w_state_next = r_state;
        w_to_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && r_buf_lock[w_pick]) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_found) begin
                    if (!r_buf_lock[w_pick]) begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_state_next = ST_IDLE;
                    w_to_fire    = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and its registered copy on the locked output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == ST_LOCKED);
        end
    end

    // Buffer occupancy: fill on handshake, drain on grant (never both at once)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_full <= '0;
            r_buf_lock <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !r_buf_full[i]) begin
                    r_buf_full[i] <= 1'b1;
                    r_buf_lock[i] <= req_lock[i];
                end else if (w_found && (w_pick == ID_W'(i))) begin
                    r_buf_full[i] <= 1'b0;
                end
            end
        end
    end

    // Buffer payload storage; the incoming valid bit is not kept
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !r_buf_full[i]) begin
                r_buf_pay[i] <= req_packet[PACKET_BITS*i +: PAY_W];
            end
        end
    end

    // Output bus, grant bookkeeping and lock owner capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cfg         <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_owner       <= '0;
        end else if (w_found) begin
            r_cfg         <= {1'b1, r_buf_pay[w_pick]};
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_pick;
            r_last_grant  <= w_pick;
            if (r_state == ST_IDLE) begin
                r_owner <= w_pick;
            end
        end else begin
            r_cfg         <= '0;
            r_grant_valid <= 1'b0;
        end
    end

    // Source valid bits are replaced by a forced 1 on emission
    always_comb begin
        w_pkt_msb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pkt_msb[i] = req_packet[PACKET_BITS*(i+1)-1];
        end
    end

`ifdef CFG_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_lock_timeout;

    // Fires on the LOCK_TIMEOUT-th consecutive idle locked cycle
    assign w_to_hit     = (r_to_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign lock_timeout = r_lock_timeout;
    assign w_unused     = ^w_pkt_msb;

    // Idle-lock counter and one-cycle release pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_cnt       <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_lock_timeout <= w_to_fire;
            if ((r_state != ST_LOCKED) || w_found || w_to_fire) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
        end
    end
`else
    localparam int unsigned UNUSED_LOCK_TIMEOUT = LOCK_TIMEOUT;

    assign w_to_hit     = 1'b0;
    assign lock_timeout = 1'b0;
    assign w_unused     = ^{w_pkt_msb, w_to_fire};
`endif

endmodule

// File: tb/tb_config_packet_arbiter.sv
// Bench for config_packet_arbiter: table-driven single-packet vectors, scripted
// multi-cycle sequences, and a randomized run against a cycle reference model.
module tb_config_packet_arbiter;

    localparam int unsigned PB  = 97;
    localparam int unsigned NR  = 4;
    localparam int unsigned LT  = 8;
    localparam int unsigned IDW = 2;
`ifdef CFG_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR*PB-1:0] req_packet = '0;
    logic [NR-1:0]    req_lock = '0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [PB-1:0]    configure_out;
    logic [IDW-1:0]   grant_id;
    logic             grant_valid;
    logic             locked;
    logic             lock_timeout;

    always #5 clk = ~clk;

    config_packet_arbiter #(
        .PACKET_BITS (PB),
        .NUM_REQ     (NR),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_packet   (req_packet),
        .req_lock     (req_lock),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .configure_out(configure_out),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .locked       (locked),
        .lock_timeout (lock_timeout)
    );

    typedef struct packed {
        logic          lock;
        logic [PB-1:0] pkt;
    } ent_t;

    typedef struct {
        int            src;
        logic [PB-1:0] pkt;
        logic [PB-1:0] exp_cfg;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic rst_req = 1'b1;
    ent_t q [NR][$];
    vec_t tbl [4];

    // reference model state (state after the next clock edge)
    logic [NR-1:0]  d_rdy_s = '0;
    logic [NR-1:0]  m_full = '0;
    logic [NR-1:0]  m_lk = '0;
    logic [PB-2:0]  m_pay [NR];
    bit             m_locked = 1'b0;
    int             m_owner = 0;
    int             m_last = NR - 1;
    int             m_idle = 0;
    int             pick;
    logic [NR-1:0]  acc;
    logic [PB-1:0]  e_cfg = '0;
    logic           e_gv = 1'b0;
    int             e_gid = 0;
    bit             e_locked = 1'b0;
    bit             e_to = 1'b0;
    bit             have_pred = 1'b0;

    int bt_gv [7] = '{1, 0, 1, 0, 1, 1, 1};
    int bt_id [7] = '{1, 0, 1, 0, 1, 3, 0};
    int bt_lk [7] = '{1, 1, 1, 1, 0, 0, 0};

    // Driver, scoreboard and reference model, all on the falling edge
    always @(negedge clk) begin
        if (have_pred) begin
            n_tests++;
            if (configure_out !== e_cfg || grant_valid !== e_gv || grant_id !== IDW'(e_gid) ||
                locked !== e_locked || lock_timeout !== e_to || req_ready !== ~m_full) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: cfg=%h gv=%b id=%0d lk=%b to=%b rdy=%b; expected cfg=%h gv=%b id=%0d lk=%b to=%b rdy=%b",
                         $time, configure_out, grant_valid, grant_id, locked, lock_timeout, req_ready,
                         e_cfg, e_gv, e_gid, e_locked, e_to, ~m_full);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && d_rdy_s[i] && reset_n && q[i].size() > 0) void'(q[i].pop_front());
        end
        reset_n = !rst_req;
        d_rdy_s = req_ready;
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_lock[i]  = q[i][0].lock;
                req_packet[PB*i +: PB] = q[i][0].pkt;
            end else begin
                req_valid[i] = 1'b0;
                req_lock[i]  = 1'b0;
                req_packet[PB*i +: PB] = '0;
            end
        end
        if (!reset_n) begin
            m_full = '0; m_lk = '0; m_locked = 1'b0; m_owner = 0; m_last = NR - 1; m_idle = 0;
            e_cfg = '0; e_gv = 1'b0; e_gid = 0; e_locked = 1'b0; e_to = 1'b0;
        end else begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                if (pick < 0 && m_full[(m_last + k) % NR] && (!m_locked || ((m_last + k) % NR) == m_owner))
                    pick = (m_last + k) % NR;
            end
            acc  = req_valid & ~m_full;
            e_to = 1'b0;
            if (pick >= 0) begin
                e_cfg = {1'b1, m_pay[pick]};
                e_gv = 1'b1;
                e_gid = pick;
                m_last = pick;
                m_full[pick] = 1'b0;
                m_idle = 0;
                if (!m_locked && m_lk[pick]) begin
                    m_locked = 1'b1;
                    m_owner = pick;
                end else if (m_locked && !m_lk[pick]) begin
                    m_locked = 1'b0;
                end
            end else begin
                e_cfg = '0;
                e_gv = 1'b0;
                if (m_locked && TO_EN) begin
                    m_idle++;
                    if (m_idle == LT) begin
                        m_locked = 1'b0;
                        e_to = 1'b1;
                        m_idle = 0;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1'b1;
                    m_pay[i]  = req_packet[PB*i +: PB-1];
                    m_lk[i]   = req_lock[i];
                end
            end
            e_locked = m_locked;
        end
        have_pred = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [PB-1:0] got, input logic [PB-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input int src, input logic lk, input logic [PB-1:0] pkt);
        ent_t e;
        e.lock = lk;
        e.pkt  = pkt;
        q[src].push_back(e);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        repeat (3) step();
        for (int i = 0; i < NR; i++) q[i].delete();
        rst_req = 1'b0;
        step();
    endtask

    initial begin
        logic [127:0] rnd;
        bit seen0, seento;
        int gv_seen;

        tbl[0] = '{2, {1'b0, 96'h1234},                       {1'b1, 96'h1234}};
        tbl[1] = '{0, {1'b1, 96'hDEAD_BEEF_0000_0001},        {1'b1, 96'hDEAD_BEEF_0000_0001}};
        tbl[2] = '{3, {1'b0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, {1'b1, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF}};
        tbl[3] = '{1, {PB{1'b0}},                              {1'b1, 96'h0}};

        // reset state
        rst_req = 1'b1;
        repeat (3) step();
        chk("rst_cfg",    configure_out, '0);
        chk("rst_ready",  PB'(req_ready), PB'(4'hF));
        chk("rst_gv",     PB'(grant_valid), '0);
        chk("rst_id",     PB'(grant_id), '0);
        chk("rst_locked", PB'(locked), '0);
        chk("rst_to",     PB'(lock_timeout), '0);
        rst_req = 1'b0;
        step();

        // single packets: one-cycle emission with valid bit forced
        for (int r = 0; r < 4; r++) begin
            push(tbl[r].src, 1'b0, tbl[r].pkt);
            step();
            chk("tbl_ready_pre",  PB'(req_ready[tbl[r].src]), PB'(1'b1));
            step();
            chk("tbl_ready_busy", PB'(req_ready[tbl[r].src]), PB'(1'b0));
            chk("tbl_gv_early",   PB'(grant_valid), '0);
            step();
            chk("tbl_gv",         PB'(grant_valid), PB'(1'b1));
            chk("tbl_id",         PB'(grant_id), PB'(tbl[r].src));
            chk("tbl_cfg",        configure_out, tbl[r].exp_cfg);
            chk("tbl_ready_post", PB'(req_ready[tbl[r].src]), PB'(1'b1));
            step();
            chk("tbl_gv_after",   PB'(grant_valid), '0);
            chk("tbl_cfg_after",  configure_out, '0);
        end

        // all four sources held valid: 0,1,2,3,0,1,2,3 back to back
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 2; j++) push(i, 1'b0, PB'(i * 16 + j));
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_gv", PB'(grant_valid), PB'(1'b1));
            chk("rr_id", PB'(grant_id), PB'(k % 4));
        end
        repeat (3) step();

        // locked burst from source 1 while 0 and 3 wait
        do_reset();
        push(0, 1'b0, PB'(96'hA0));
        repeat (4) step();
        push(0, 1'b0, PB'(96'hB0));
        push(1, 1'b1, PB'(96'hB1));
        push(1, 1'b1, PB'(96'hB2));
        push(1, 1'b0, PB'(96'hB3));
        push(3, 1'b0, PB'(96'hB4));
        step();
        step();
        for (int c = 0; c < 7; c++) begin
            step();
            chk("burst_gv", PB'(grant_valid), PB'(bt_gv[c]));
            if (bt_gv[c] == 1) chk("burst_id", PB'(grant_id), PB'(bt_id[c]));
            chk("burst_locked", PB'(locked), PB'(bt_lk[c]));
            if (c < 4) chk("burst_waiters_ready", PB'(req_ready[0] | req_ready[3]), '0);
        end
        repeat (3) step();

        // reset in the middle of a lock with three buffers full
        do_reset();
        push(1, 1'b1, PB'(96'hC1));
        step();
        push(0, 1'b0, PB'(96'hC0));
        push(2, 1'b0, PB'(96'hC2));
        push(3, 1'b0, PB'(96'hC3));
        step();
        step();
        chk("midlock_locked", PB'(locked), PB'(1'b1));
        chk("midlock_ready",  PB'(req_ready), PB'(4'b0010));
        rst_req = 1'b1;
        step();
        step();
        chk("midrst_ready",  PB'(req_ready), PB'(4'hF));
        chk("midrst_gv",     PB'(grant_valid), '0);
        chk("midrst_locked", PB'(locked), '0);
        chk("midrst_cfg",    configure_out, '0);
        for (int i = 0; i < NR; i++) q[i].delete();
        rst_req = 1'b0;
        gv_seen = 0;
        repeat (12) begin
            step();
            if (grant_valid) gv_seen++;
        end
        chk("postrst_quiet", PB'(gv_seen), '0);

        // lock held by an idle source with source 0 pending
        do_reset();
        push(1, 1'b1, PB'(96'hD1));
        step();
        push(0, 1'b0, PB'(96'hD0));
        step();
        step();
        chk("to_grant_gv", PB'(grant_valid), PB'(1'b1));
        chk("to_grant_id", PB'(grant_id), PB'(1));
        chk("to_grant_lk", PB'(locked), PB'(1'b1));
`ifdef CFG_ARB_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("to_pulse",  PB'(lock_timeout), PB'(k == 8));
            chk("to_locked", PB'(locked), PB'(k < 8));
            chk("to_idle_gv", PB'(grant_valid), '0);
        end
        step();
        chk("to_after_gv", PB'(grant_valid), PB'(1'b1));
        chk("to_after_id", PB'(grant_id), '0);
        chk("to_after_lk", PB'(locked), '0);
        chk("to_after_pulse", PB'(lock_timeout), '0);
`else
        seen0  = 1'b0;
        seento = 1'b0;
        repeat (1000) begin
            step();
            if (grant_valid && grant_id == 0) seen0 = 1'b1;
            if (lock_timeout) seento = 1'b1;
        end
        chk("nolock_to_src0", PB'(seen0), '0);
        chk("nolock_to_pulse", PB'(seento), '0);
        chk("nolock_to_locked", PB'(locked), PB'(1'b1));
`endif

        // randomized traffic against the reference model
        do_reset();
        repeat (3000) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() < 2 && $urandom_range(3) == 0) begin
                    rnd = {$urandom, $urandom, $urandom, $urandom};
                    push(i, ($urandom_range(4) == 0), PB'(rnd));
                end
            end
        end
        do_reset();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_packet_arbiter.md
Name: config_packet_arbiter

Overview:
- Merges configuration packets from NUM_REQ independent sources onto the single registered configuration packet bus that drives the leaf Config_Controls blocks.
- Sources include the host loader, the freespace-credit return path and debug. Each source has a 1-deep holding buffer.
- Grants are round-robin.
- A source may lock the bus across a burst, so a leaf's in-port and out-port registers are programmed without interleaving.

Parameters:
- PACKET_BITS, 97: packet width. MSB is the valid bit; the layout below the MSB is opaque to this block.
- NUM_REQ, 4: number of requesting sources, must be >= 2.
- LOCK_TIMEOUT, 255: lock-idle cycles before forced release. Used only with the optional feature; must be >= 1.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- reset_n, input, 1: synchronous reset, active-low.
- req_packet, input, NUM_REQ*PACKET_BITS: source i packet at slice [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- req_lock, input, NUM_REQ: per-source lock request, sampled together with the packet.
- req_valid, input, NUM_REQ: per-source packet valid.
- req_ready, output, NUM_REQ: per-source buffer-empty indication.
- configure_out, output, PACKET_BITS: registered packet bus to the leaves.
- grant_id, output, max(1,$clog2(NUM_REQ)): index of the source emitted this cycle.
- grant_valid, output, 1: high for exactly the cycles where configure_out carries a packet.
- locked, output, 1: arbiter is in the LOCKED state.
- lock_timeout, output, 1: one-cycle pulse on forced lock release.

Behaviour:
- Reset (reset_n=0 at an edge):
  - All buffers empty; configure_out=0, grant_valid=0, grant_id=0, locked=0, lock_timeout=0.
  - State IDLE; last_grant=NUM_REQ-1, so source 0 is first priority.
  - Timeout counter cleared.
  - Applies mid-burst and mid-lock. Buffered packets are discarded and never emitted.
- Handshake:
  - req_ready[i] = !buf_full[i], driven from a register with no combinational path from req_valid.
  - A transfer happens when req_valid[i] && req_ready[i] at an edge. The buffer captures packet and lock, and buf_full[i] is set.
  - req_valid asserted while ready=0 is ignored; the source must hold its packet.
  - Maximum per-source throughput is 1 packet per 2 cycles.
- Arbitration (every edge, when not in reset):
  - Candidate set:
    - IDLE: all full buffers.
    - LOCKED: the owner's buffer only.
  - Pick the first candidate searching last_grant+1, last_grant+2, ... modulo NUM_REQ, with wrap-around.
  - If a candidate exists, the same edge does all of the following:
    - configure_out <= {1'b1, buf_pkt[i][PACKET_BITS-2:0]} (valid bit forced to 1).
    - grant_valid<=1, grant_id<=i, last_grant<=i.
    - buf_full[i]<=0.
  - Otherwise configure_out<=0 (all bits), grant_valid<=0, grant_id holds.
  - Each packet appears on configure_out for exactly one cycle.
- Latency: transfer accepted at edge E0 → configure_out valid after edge E1 (if granted) → req_ready[i] high again after E1.
- State machine:
  - IDLE → LOCKED when the emitted packet has lock=1; owner<=i.
  - LOCKED → IDLE when the owner emits a packet with lock=0. That packet is still emitted.
  - LOCKED → IDLE on timeout (optional feature only).
  - While LOCKED, a LOCKED-owner packet with lock=1 keeps the lock.
  - locked is a registered copy of the state.
- Simultaneous events:
  - A buffer cannot accept and be emitted on the same edge: accept requires empty, emit requires full.
  - Other sources may load while one source emits.
- Non-owner buffers stay full while LOCKED. Their req_ready stays 0.

Optional Feature:
- Macro: CFG_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(LOCK_TIMEOUT+1) counts LOCKED cycles with no owner emission.
  - The counter clears on any owner emission and on entering LOCKED.
  - When the counter reaches LOCK_TIMEOUT: state→IDLE, lock_timeout pulses 1 for one cycle, counter clears.
  - Arbitration on the next edge uses the IDLE candidate set, from last_grant (the owner) +1.
- Not defined:
  - A lock is held indefinitely.
  - lock_timeout is tied to 0; no counter logic.

Test Plan:
- Reset → configure_out=0, req_ready=4'b1111, grant_valid=0, locked=0. Assert reset_n=0 mid-lock with 3 buffers full → all cleared, no packet emitted afterwards.
- Source 2 sends payload 0x0...1234 with MSB=0, lock=0 → one cycle later configure_out={1'b1, ...1234}, grant_id=2, grant_valid for exactly 1 cycle, then req_ready[2]=1.
- All 4 sources valid on the same edge, held valid → emission order 0,1,2,3 on 4 consecutive cycles. Refilled buffers are served 0,1,2,3 again with no starvation.
- Source 1 sends 3 packets lock=1,1,0 while sources 0 and 3 hold packets → outputs 1,1,1 (locked=1 until after the third), then 3,0.
- With the macro, LOCK_TIMEOUT=8: source 1 sends lock=1 then goes idle, source 0 pending → lock_timeout pulses 8 idle cycles after the grant, then source 0 is emitted on the next cycle and locked=0.
- Without the macro, same stimulus → source 0 is never emitted within 1000 cycles, lock_timeout stays 0.
